// File: rtl/output_port_scheduler.sv
// Round-robin output-port arbiter with packet lock: holds a one-hot grant from
// the first flit to the flit marked last, and flags a grant that stops moving.
module output_port_scheduler #(
  parameter int NUM_REQ   = 5,
  parameter int STALL_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [2:0]         gnt_idx,
  output logic               xfer,
  output logic               stall
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_REQ - 1);

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               valid_reg, valid_next;
  logic [2:0]         idx_reg, idx_next;
  logic [2:0]         ptr_reg, ptr_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic               stall_reg, stall_next;

  logic               any_req;
  logic               req_held;
  logic               last_held;
  logic               release_evt;
  logic [2:0]         idx_plus1;
  logic [2:0]         pick_idle;
  logic [2:0]         pick_rel;

  // First set request at or above start, wrapping; start is always < NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [2:0] start);
    logic [2*NUM_REQ-1:0] rot;
    logic [2:0]           off;
    logic [3:0]           sum;
    rot = {r, r} >> start;
    off = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
    return sum[2:0];
  endfunction

  assign any_req     = |req;
  assign req_held    = req[idx_reg];
  assign last_held   = last[idx_reg];
  assign idx_plus1   = (idx_reg == LAST_IDX) ? 3'd0 : idx_reg + 3'd1;
  assign pick_idle   = rr_pick(req, ptr_reg);
  assign pick_rel    = rr_pick(req, idx_plus1);
  // A withdrawn request also ends the packet; it can never coincide with xfer.
  assign release_evt = !req_held || (xfer && last_held);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      idx_reg   <= 3'd0;
      ptr_reg   <= 3'd0;
      cnt_reg   <= 8'd0;
      stall_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      stall_reg <= stall_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (any_req) begin
          state_next = HOLD;
          valid_next = 1'b1;
          idx_next   = pick_idle;
        end
      end
      HOLD: begin
        if (release_evt) begin
          ptr_next = idx_plus1;
          cnt_next = 8'd0;
          if (any_req) begin
            // Searching from idx+1 puts the releasing input last in line.
            idx_next = pick_rel;
          end else begin
            state_next = IDLE;
            valid_next = 1'b0;
            idx_next   = 3'd0;
          end
        end else if (xfer) begin
          cnt_next = 8'd0;
        end else if (cnt_reg < STALL_LIMIT) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        idx_next   = 3'd0;
        cnt_next   = 8'd0;
      end
    endcase
    stall_next = (cnt_next == STALL_LIMIT);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign gnt_next[gi] = valid_next && (idx_next == 3'(gi));
    end
  endgenerate

  // Output logic
  always_comb begin
    xfer      = valid_reg && out_ready && req_held;
    gnt       = gnt_reg;
    gnt_valid = valid_reg;
    gnt_idx   = idx_reg;
    stall     = stall_reg;
  end

endmodule

// File: doc/output_port_scheduler.md
OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 5, number of requesting input ports, indexed NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4.
REQ-002 Parameter STALL_MAX, default 16, consecutive no-transfer grant cycles before the stall flag asserts; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserting rst=0 forces reset state immediately, independent of clk.
REQ-005 req  input  NUM_REQ  per-input request for this output port, bit i from input i's route block.
REQ-006 last  input  NUM_REQ  per-input end-of-packet marker, sampled only for the granted input.
REQ-007 out_ready  input  1  downstream output register can accept a flit this cycle.
REQ-008 gnt  output  NUM_REQ  registered one-hot grant; all zero when no grant is held.
REQ-009 gnt_valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-010 gnt_idx  output  3  registered binary index of the granted input; 0 when gnt_valid=0.
REQ-011 xfer  output  1  combinational; = gnt_valid & out_ready & req[gnt_idx]; marks a flit moved this cycle.
REQ-012 stall  output  1  registered; 1 while a grant has been held STALL_MAX or more cycles without xfer.

Function
REQ-013 The FSM SHALL have two states: IDLE (no grant) and HOLD (grant held).
REQ-014 IDLE with req!=0 at edge n: SHALL enter HOLD and present gnt/gnt_valid/gnt_idx from edge n+1 (one-cycle arbitration latency).
REQ-015 Selection SHALL be round-robin: the first set req bit searching upward from ptr, wrapping NUM_REQ-1 to 0.
REQ-016 ptr SHALL be a 3-bit register, reset 0, always in 0..NUM_REQ-1.
REQ-017 In HOLD, gnt SHALL stay stable while no release condition occurs, regardless of other req bits.
REQ-018 In HOLD, xfer with last[gnt_idx]=0: grant held (packet lock), ptr unchanged, stall counter cleared.
REQ-019 In HOLD, xfer with last[gnt_idx]=1: release; ptr <= (gnt_idx+1) mod NUM_REQ.
REQ-020 In HOLD, req[gnt_idx]=0 (withdrawal, so no xfer): release; ptr <= (gnt_idx+1) mod NUM_REQ.
REQ-021 On release, if any req bit is set at the same edge: re-arbitrate with the updated ptr and load the new grant at that edge (no idle bubble); otherwise go to IDLE with gnt=0.
REQ-022 On the re-arbitration in REQ-021, the releasing input SHALL have lowest priority; if it is the only requester, it SHALL be re-granted.
REQ-023 Stall counter: 8-bit, counts HOLD cycles with xfer=0, saturates at STALL_MAX, and clears on xfer, on release, and in IDLE.
REQ-024 stall SHALL be registered, = (counter == STALL_MAX), and deassert on the edge after xfer or release.
REQ-025 last bits of non-granted inputs and out_ready in IDLE SHALL have no effect.
REQ-026 gnt SHALL never have more than one bit set, and SHALL never point at an input whose req was 0 at the grant edge.

Reset
REQ-027 With rst=0: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, counter=0, stall=0; xfer=0 follows from gnt_valid=0.
REQ-028 Reset asserted mid-packet SHALL drop the grant and lock immediately; after release, arbitration restarts from ptr=0.
REQ-029 The first arbitration SHALL occur at the first rising edge with rst=1.

Verification
REQ-030 Reset release, req=5'b10100 held, out_ready=1, last=all 1s -> gnt sequence 00100, 10000, 00100, ...; one grant per cycle; 1-cycle latency from the first edge.
REQ-031 req=5'b11111, out_ready=1, last=all 1s for 10 cycles -> gnt_idx 0,1,2,3,4,0,1,2,3,4; xfer=1 on every cycle.
REQ-032 Grant on input 1, 3-flit packet (last=0,0,1), req[3]=1 throughout -> gnt stays 00010 for 3 xfers, then 01000 on the next cycle.
REQ-033 Grant on input 2 with out_ready=0 for 20 cycles, STALL_MAX=16 -> stall rises after 16 held cycles, gnt unchanged; out_ready=1 with last=1 -> xfer, then stall=0 and the grant moves on the next edge.
REQ-034 Grant on input 0, then req[0] drops with out_ready=0 and req[4]=1 -> next edge gnt=10000, ptr=1, xfer never asserted for input 0.
REQ-035 rst=0 pulsed asynchronously (between edges) while locked mid-packet on input 3 -> outputs zero immediately; after reset release with req=5'b01000, gnt=01000 after 1 cycle, ptr search starting from 0.
